// File: rtl/axi4_pipe_slice.sv
// axi4_pipe_slice -- full-throughput AXI4 register slice.
//
// Every channel (AW, W, B, AR, R) goes through a 2-entry skid buffer. That
// breaks all combinational paths between the two sides, costs one cycle of
// latency, and adds no bubbles at 100% throughput.
//
// Ports
//   slaver_axi_aclk      in   single clock for the whole block
//   slaver_axi_aresetn   in   asynchronous, active-low reset
//   slaver_axi_aw*/w*/ar*     upstream requests in; *ready out
//   slaver_axi_b*/r*          upstream responses out; *ready in
//   master_axi_aw*/w*/ar*     downstream requests out; *ready in
//   master_axi_b*/r*          downstream responses in; *ready out
//
// Parameters
//   MODE            "BOTH" | "ONLY_READ" | "ONLY_WRITE". A channel set that
//                   is not built has all of its outputs tied to 0.
//   SLICE_MASK      per-channel enable {R,AR,B,W,AW}. A 0 bit makes that
//                   channel a plain wire pass-through.
//   IGNORE_IDSIZE   "TRUE" skips the elaboration check S_ID_W <= M_ID_W.
//   IGNORE_DSIZE    "TRUE" skips the elaboration check S_DATA_W == M_DATA_W.
//
// AW/AR IDs are zero-extended from S_ID_W to M_ID_W. B/R IDs are truncated
// back to S_ID_W. wlast and rlast are ordinary payload bits.

// Skid buffer for one channel.
//
//   state | meaning
//   EMPTY | nothing held; dst_valid = 0
//   ONE   | main register holds the beat presented at dst
//   TWO   | main and skid registers both full; src_ready = 0
module axi4_pipe_slice_skid #(
  parameter int W     = 8,
  parameter bit BUILD = 1'b1,
  parameter bit SLICE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         dst_valid,
  input  logic         dst_ready,
  output logic [W-1:0] dst_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  if (!BUILD) begin : g_off
    assign src_ready = 1'b0;
    assign dst_valid = 1'b0;
    assign dst_data  = '0;
  end else if (!SLICE) begin : g_wire
    assign src_ready = dst_ready;
    assign dst_valid = src_valid;
    assign dst_data  = src_data;
  end else begin : g_skid
    state_e         state_q, state_d;
    logic           rdy_q, rdy_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   s_q, s_d;
    logic           src_beat, dst_beat;

    assign src_beat  = src_valid & rdy_q;
    assign dst_beat  = (state_q != EMPTY) & dst_ready;
    assign src_ready = rdy_q;
    assign dst_valid = (state_q != EMPTY);
    assign dst_data  = m_q;

    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
        EMPTY: begin
          if (src_beat) begin
            m_d     = src_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (src_beat && dst_beat) begin
            m_d = src_data;
          end else if (src_beat) begin
            s_d     = src_data;
            state_d = TWO;
          end else if (dst_beat) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (dst_beat) begin
            m_d     = s_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Ready is a flop so it never depends combinationally on dst_ready.
      rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rdy_q   <= rdy_d;
      end
    end

    // Payload needs no reset; it is qualified by the state.
    always_ff @(posedge clk) begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

endmodule

module axi4_pipe_slice #(
  parameter string      MODE          = "BOTH",
  parameter logic [4:0] SLICE_MASK    = 5'b11111,
  parameter string      IGNORE_IDSIZE = "FALSE",
  parameter string      IGNORE_DSIZE  = "FALSE",
  parameter int         S_ID_W        = 4,
  parameter int         M_ID_W        = 4,
  parameter int         ADDR_W        = 32,
  parameter int         S_DATA_W      = 32,
  parameter int         M_DATA_W      = 32
) (
  input  logic                  slaver_axi_aclk,
  input  logic                  slaver_axi_aresetn,
  // slaver AW
  input  logic [S_ID_W-1:0]     slaver_axi_awid,
  input  logic [ADDR_W-1:0]     slaver_axi_awaddr,
  input  logic [7:0]            slaver_axi_awlen,
  input  logic [2:0]            slaver_axi_awsize,
  input  logic [1:0]            slaver_axi_awburst,
  input  logic                  slaver_axi_awlock,
  input  logic [3:0]            slaver_axi_awcache,
  input  logic [2:0]            slaver_axi_awprot,
  input  logic [3:0]            slaver_axi_awqos,
  input  logic                  slaver_axi_awvalid,
  output logic                  slaver_axi_awready,
  // slaver W
  input  logic [S_DATA_W-1:0]   slaver_axi_wdata,
  input  logic [S_DATA_W/8-1:0] slaver_axi_wstrb,
  input  logic                  slaver_axi_wlast,
  input  logic                  slaver_axi_wvalid,
  output logic                  slaver_axi_wready,
  // slaver B
  output logic [S_ID_W-1:0]     slaver_axi_bid,
  output logic [1:0]            slaver_axi_bresp,
  output logic                  slaver_axi_bvalid,
  input  logic                  slaver_axi_bready,
  // slaver AR
  input  logic [S_ID_W-1:0]     slaver_axi_arid,
  input  logic [ADDR_W-1:0]     slaver_axi_araddr,
  input  logic [7:0]            slaver_axi_arlen,
  input  logic [2:0]            slaver_axi_arsize,
  input  logic [1:0]            slaver_axi_arburst,
  input  logic                  slaver_axi_arlock,
  input  logic [3:0]            slaver_axi_arcache,
  input  logic [2:0]            slaver_axi_arprot,
  input  logic [3:0]            slaver_axi_arqos,
  input  logic                  slaver_axi_arvalid,
  output logic                  slaver_axi_arready,
  // slaver R
  output logic [S_ID_W-1:0]     slaver_axi_rid,
  output logic [S_DATA_W-1:0]   slaver_axi_rdata,
  output logic [1:0]            slaver_axi_rresp,
  output logic                  slaver_axi_rlast,
  output logic                  slaver_axi_rvalid,
  input  logic                  slaver_axi_rready,
  // master AW
  output logic [M_ID_W-1:0]     master_axi_awid,
  output logic [ADDR_W-1:0]     master_axi_awaddr,
  output logic [7:0]            master_axi_awlen,
  output logic [2:0]            master_axi_awsize,
  output logic [1:0]            master_axi_awburst,
  output logic                  master_axi_awlock,
  output logic [3:0]            master_axi_awcache,
  output logic [2:0]            master_axi_awprot,
  output logic [3:0]            master_axi_awqos,
  output logic                  master_axi_awvalid,
  input  logic                  master_axi_awready,
  // master W
  output logic [M_DATA_W-1:0]   master_axi_wdata,
  output logic [M_DATA_W/8-1:0] master_axi_wstrb,
  output logic                  master_axi_wlast,
  output logic                  master_axi_wvalid,
  input  logic                  master_axi_wready,
  // master B
  input  logic [M_ID_W-1:0]     master_axi_bid,
  input  logic [1:0]            master_axi_bresp,
  input  logic                  master_axi_bvalid,
  output logic                  master_axi_bready,
  // master AR
  output logic [M_ID_W-1:0]     master_axi_arid,
  output logic [ADDR_W-1:0]     master_axi_araddr,
  output logic [7:0]            master_axi_arlen,
  output logic [2:0]            master_axi_arsize,
  output logic [1:0]            master_axi_arburst,
  output logic                  master_axi_arlock,
  output logic [3:0]            master_axi_arcache,
  output logic [2:0]            master_axi_arprot,
  output logic [3:0]            master_axi_arqos,
  output logic                  master_axi_arvalid,
  input  logic                  master_axi_arready,
  // master R
  input  logic [M_ID_W-1:0]     master_axi_rid,
  input  logic [M_DATA_W-1:0]   master_axi_rdata,
  input  logic [1:0]            master_axi_rresp,
  input  logic                  master_axi_rlast,
  input  logic                  master_axi_rvalid,
  output logic                  master_axi_rready
);

  localparam bit BUILD_WR = (MODE != "ONLY_READ");
  localparam bit BUILD_RD = (MODE != "ONLY_WRITE");

  localparam int AX_W = M_ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4;
  localparam int W_W  = S_DATA_W + S_DATA_W / 8 + 1;
  localparam int B_W  = S_ID_W + 2;
  localparam int R_W  = S_ID_W + S_DATA_W + 2 + 1;

  if (IGNORE_IDSIZE == "FALSE" && S_ID_W > M_ID_W) begin : g_chk_id
    $error("axi4_pipe_slice: slaver ID width exceeds master ID width");
  end
  if (IGNORE_DSIZE == "FALSE" && S_DATA_W != M_DATA_W) begin : g_chk_data
    $error("axi4_pipe_slice: slaver and master data widths differ");
  end

  logic [AX_W-1:0] aw_src, aw_dst, ar_src, ar_dst;
  logic [W_W-1:0]  w_src, w_dst;
  logic [B_W-1:0]  b_src, b_dst;
  logic [R_W-1:0]  r_src, r_dst;

  // IDs are resized on the way in, so the registers hold only what leaves.
  assign aw_src = {M_ID_W'(slaver_axi_awid), slaver_axi_awaddr, slaver_axi_awlen,
                   slaver_axi_awsize, slaver_axi_awburst, slaver_axi_awlock,
                   slaver_axi_awcache, slaver_axi_awprot, slaver_axi_awqos};
  assign {master_axi_awid, master_axi_awaddr, master_axi_awlen, master_axi_awsize,
          master_axi_awburst, master_axi_awlock, master_axi_awcache,
          master_axi_awprot, master_axi_awqos} = aw_dst;

  assign w_src = {slaver_axi_wdata, slaver_axi_wstrb, slaver_axi_wlast};
  assign {master_axi_wdata, master_axi_wstrb, master_axi_wlast} = w_dst;

  assign b_src = {S_ID_W'(master_axi_bid), master_axi_bresp};
  assign {slaver_axi_bid, slaver_axi_bresp} = b_dst;

  assign ar_src = {M_ID_W'(slaver_axi_arid), slaver_axi_araddr, slaver_axi_arlen,
                   slaver_axi_arsize, slaver_axi_arburst, slaver_axi_arlock,
                   slaver_axi_arcache, slaver_axi_arprot, slaver_axi_arqos};
  assign {master_axi_arid, master_axi_araddr, master_axi_arlen, master_axi_arsize,
          master_axi_arburst, master_axi_arlock, master_axi_arcache,
          master_axi_arprot, master_axi_arqos} = ar_dst;

  assign r_src = {S_ID_W'(master_axi_rid), master_axi_rdata, master_axi_rresp,
                  master_axi_rlast};
  assign {slaver_axi_rid, slaver_axi_rdata, slaver_axi_rresp, slaver_axi_rlast} = r_dst;

  axi4_pipe_slice_skid #(.W(AX_W), .BUILD(BUILD_WR), .SLICE(SLICE_MASK[0])) u_aw (
    .clk(slaver_axi_aclk), .rst_n(slaver_axi_aresetn),
    .src_valid(slaver_axi_awvalid), .src_ready(slaver_axi_awready), .src_data(aw_src),
    .dst_valid(master_axi_awvalid), .dst_ready(master_axi_awready), .dst_data(aw_dst));

  axi4_pipe_slice_skid #(.W(W_W), .BUILD(BUILD_WR), .SLICE(SLICE_MASK[1])) u_w (
    .clk(slaver_axi_aclk), .rst_n(slaver_axi_aresetn),
    .src_valid(slaver_axi_wvalid), .src_ready(slaver_axi_wready), .src_data(w_src),
    .dst_valid(master_axi_wvalid), .dst_ready(master_axi_wready), .dst_data(w_dst));

  axi4_pipe_slice_skid #(.W(B_W), .BUILD(BUILD_WR), .SLICE(SLICE_MASK[2])) u_b (
    .clk(slaver_axi_aclk), .rst_n(slaver_axi_aresetn),
    .src_valid(master_axi_bvalid), .src_ready(master_axi_bready), .src_data(b_src),
    .dst_valid(slaver_axi_bvalid), .dst_ready(slaver_axi_bready), .dst_data(b_dst));

  axi4_pipe_slice_skid #(.W(AX_W), .BUILD(BUILD_RD), .SLICE(SLICE_MASK[3])) u_ar (
    .clk(slaver_axi_aclk), .rst_n(slaver_axi_aresetn),
    .src_valid(slaver_axi_arvalid), .src_ready(slaver_axi_arready), .src_data(ar_src),
    .dst_valid(master_axi_arvalid), .dst_ready(master_axi_arready), .dst_data(ar_dst));

  axi4_pipe_slice_skid #(.W(R_W), .BUILD(BUILD_RD), .SLICE(SLICE_MASK[4])) u_r (
    .clk(slaver_axi_aclk), .rst_n(slaver_axi_aresetn),
    .src_valid(master_axi_rvalid), .src_ready(master_axi_rready), .src_data(r_src),
    .dst_valid(slaver_axi_rvalid), .dst_ready(slaver_axi_rready), .dst_data(r_dst));

endmodule
